// File: rtl/fifo1c_rd_stream_pkg.sv
// Shared types and constants for the link-engine FIFO read-side drain stage.
// Optional statistics counters are enabled with LE_RDSTREAM_STATS_EN.
package fifo1c_rd_stream_pkg;

  localparam int LE_FIFO_DW = 108;
  localparam int RD_LAT_MAX = 3;
  localparam int STATS_W    = 32;

  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  typedef logic [LE_FIFO_DW-1:0] le_word_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo1c_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream of the drain stage.
// master = drain stage view, slave = FIFO/framer side view.
interface fifo1c_rd_stream_if
  import fifo1c_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = LE_FIFO_DW,
  parameter int BUF_DEPTH  = 4
);

  logic                         fifo_empty;
  logic [DATA_WIDTH-1:0]        fifo_q;
  logic                         fifo_rdreq;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_ready;
  logic                         flush;
  logic [$clog2(BUF_DEPTH):0]   buf_level;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    output fifo_rdreq,
    output out_valid,
    output out_data,
    input  out_ready,
    input  flush,
    output buf_level
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    input  fifo_rdreq,
    input  out_valid,
    input  out_data,
    output out_ready,
    output flush,
    input  buf_level
  );

endinterface

// File: rtl/fifo1c_rd_skid.sv
// Small register FIFO holding words returned by the link FIFO until the framer accepts them.
// The head entry drives the stream directly; flush empties it in one cycle.
module fifo1c_rd_skid
  import fifo1c_rd_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = LE_FIFO_DW,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [LVL_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (level_reg != '0);
  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((level_reg != LVL_W'(DEPTH)) || do_pop);

  always_comb begin
    level_next = level_reg;
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_next;
    end
  end

  assign head_valid = (level_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign level      = level_reg;

endmodule

// File: rtl/fifo1c_rd_stream.sv
// Drain stage: credit-gated pops from a fixed-latency FIFO into a valid/ready stream.
// Define LE_RDSTREAM_STATS_EN to add the accepted-beat and stall counters.
module fifo1c_rd_stream
  import fifo1c_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = LE_FIFO_DW,
  parameter int RD_LAT     = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef LE_RDSTREAM_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] word_cnt,
  output logic [STATS_W-1:0] stall_cnt,
`endif
  fifo1c_rd_stream_if.master bus
);

  localparam int LVL_W = $clog2(BUF_DEPTH) + 1;

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("fifo1c_rd_stream: RD_LAT must be 1..3");
    end
    if (!is_pow2(BUF_DEPTH) || BUF_DEPTH < RD_LAT + 2) begin : g_bad_depth
      $error("fifo1c_rd_stream: BUF_DEPTH must be a power of two and >= RD_LAT+2");
    end
  endgenerate

  logic [RD_LAT-1:0]     issue_sr_reg;
  logic [RD_LAT-1:0]     issue_sr_next;
  logic [LVL_W-1:0]      discard_reg;
  logic [LVL_W-1:0]      discard_next;
  logic [LVL_W-1:0]      inflight;
  logic [LVL_W-1:0]      level;
  logic [LVL_W:0]        credit_used;
  logic                  issue;
  logic                  capture;
  logic                  keep;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  accept;

  // Credits count both buffered words and words still travelling through the FIFO read pipe.
  assign inflight    = LVL_W'($countones(issue_sr_reg));
  assign credit_used = {1'b0, level} + {1'b0, inflight};
  assign issue       = !rst && !bus.flush && !bus.fifo_empty &&
                       (credit_used < (LVL_W + 1)'(BUF_DEPTH));
  assign capture     = issue_sr_reg[RD_LAT-1];
  assign keep        = capture && (discard_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_sr
      if (gi == 0) begin : g_head
        assign issue_sr_next[gi] = issue;
      end else begin : g_tail
        assign issue_sr_next[gi] = issue_sr_reg[gi-1];
      end
    end
  endgenerate

  // Words already returning in the flush cycle are dropped with the buffer, so they are not re-counted.
  always_comb begin
    discard_next = discard_reg;
    if (bus.flush) begin
      discard_next = inflight - LVL_W'(capture);
    end else if (capture && (discard_reg != '0)) begin
      discard_next = discard_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_sr_reg <= '0;
      discard_reg  <= '0;
    end else begin
      issue_sr_reg <= issue_sr_next;
      discard_reg  <= discard_next;
    end
  end

  fifo1c_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .push       (keep),
    .push_data  (bus.fifo_q),
    .pop        (accept),
    .head_valid (head_valid),
    .head_data  (head_data),
    .level      (level)
  );

  assign accept         = head_valid && bus.out_ready;
  assign bus.fifo_rdreq = issue;
  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head_data;
  assign bus.buf_level  = level;

`ifdef LE_RDSTREAM_STATS_EN
  logic [STATS_W-1:0] word_cnt_reg;
  logic [STATS_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      word_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (accept && (word_cnt_reg != STATS_MAX)) begin
        word_cnt_reg <= word_cnt_reg + STATS_W'(1);
      end
      if (head_valid && !bus.out_ready && (stall_cnt_reg != STATS_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + STATS_W'(1);
      end
    end
  end

  assign word_cnt  = word_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
